// File: rtl/tis_exec_ctl.sv
// tis_exec_ctl: execution sequencer for one TIS core.
// Streams LOAD words into program memory, tracks program length, and drives the
// core's reset and per-instruction enable in RUN / STEP / HALT modes with one
// PC breakpoint. Commands arrive on a valid/ready handshake.
module tis_exec_ctl #(
  parameter int PROG_DEPTH = 15,
  parameter int INSTR_W    = 16,
  parameter int PC_W       = 4,
  parameter int RUN_DIV    = 5_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [INSTR_W-1:0] cmd_data,
  output logic               prog_we,
  output logic [PC_W-1:0]    prog_addr,
  output logic [INSTR_W-1:0] prog_wdata,
  output logic [PC_W-1:0]    plength,
  output logic               core_rst,
  output logic               core_en,
  input  logic [PC_W-1:0]    core_pc,
  input  logic               bp_en,
  input  logic [PC_W-1:0]    bp_addr,
  output logic [1:0]         state,
  output logic               bp_hit,
  output logic               load_ovf,
  output logic [15:0]        instr_count
);

  // RUN_DIV >= 2, so $clog2 always yields a width able to hold RUN_DIV-1.
  localparam int                DIV_W    = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PC_W-1:0]   DEPTH_P  = PC_W'(PROG_DEPTH);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_PAUSE = 2'b11
  } state_e;

  state_e             state_q;
  logic               prog_we_q;
  logic [PC_W-1:0]    prog_addr_q;
  logic [INSTR_W-1:0] prog_wdata_q;
  logic [PC_W-1:0]    ptr_q;        // write pointer, doubles as plength
  logic               load_ovf_q;
  logic               bp_hit_q;
  logic [15:0]        cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic               skip_q;       // first terminal count after entering RUN ignores the breakpoint
  logic               step_q;       // STEP pulse queued for the next cycle

  logic               cmd_acc;
  logic               acc_load;
  logic               acc_run;
  logic               acc_step;
  logic               acc_halt;
  logic               tc;
  logic               bp_stop;
  logic               run_pulse;
  logic [DIV_W-1:0]   div_d;
  logic [15:0]        cnt_d;

  // Memory needs two cycles per word, so the handshake stalls while a write is in flight.
  assign cmd_ready   = ~rst & ~prog_we_q;
  assign core_rst    = (state_q == S_IDLE) | (state_q == S_LOAD);
  assign core_en     = ~rst & (run_pulse | step_q);
  assign state       = state_q;
  assign prog_we     = prog_we_q;
  assign prog_addr   = prog_addr_q;
  assign prog_wdata  = prog_wdata_q;
  assign plength     = ptr_q;
  assign bp_hit      = bp_hit_q;
  assign load_ovf    = load_ovf_q;
  assign instr_count = cnt_q;

  // Command decode, terminal-count detection and the RUN-mode pulse decision.
  always_comb begin
    cmd_acc   = cmd_valid & cmd_ready;
    acc_load  = cmd_acc & (cmd_op == OP_LOAD);
    acc_run   = cmd_acc & (cmd_op == OP_RUN);
    acc_step  = cmd_acc & (cmd_op == OP_STEP);
    acc_halt  = cmd_acc & (cmd_op == OP_HALT);
    tc        = (state_q == S_RUN) & (div_q == DIV_LAST);
    // A HALT landing on the terminal count wins over the breakpoint; neither pulses.
    bp_stop   = tc & ~skip_q & bp_en & (core_pc == bp_addr) & ~acc_halt;
    run_pulse = tc & ~acc_halt & ~bp_stop & (ptr_q != '0);
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    cnt_d     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  // Sequencer FSM with its registered memory-write port, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wdata_q <= '0;
      ptr_q        <= '0;
      load_ovf_q   <= 1'b0;
      bp_hit_q     <= 1'b0;
      cnt_q        <= '0;
      div_q        <= '0;
      skip_q       <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      step_q    <= 1'b0;
      if (core_en) begin
        cnt_q <= cnt_d;
      end
      if (cmd_acc && (cmd_op != OP_HALT)) begin
        bp_hit_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (acc_load) begin
            // A fresh load always restarts at address 0.
            state_q      <= S_LOAD;
            load_ovf_q   <= 1'b0;
            prog_we_q    <= 1'b1;
            prog_addr_q  <= '0;
            prog_wdata_q <= cmd_data;
            ptr_q        <= PC_W'(1);
          end else if (acc_run) begin
            state_q <= S_RUN;
            div_q   <= '0;
            skip_q  <= 1'b1;
          end else if (acc_step) begin
            // From IDLE the core first has to leave reset, so no pulse yet.
            state_q <= S_PAUSE;
            if ((state_q == S_PAUSE) && (ptr_q != '0)) begin
              step_q <= 1'b1;
            end
          end else if (acc_halt) begin
            state_q <= S_PAUSE;
          end
        end
        S_LOAD: begin
          if (acc_load) begin
            if (ptr_q == DEPTH_P) begin
              load_ovf_q <= 1'b1;
            end else begin
              prog_we_q    <= 1'b1;
              prog_addr_q  <= ptr_q;
              prog_wdata_q <= cmd_data;
              ptr_q        <= ptr_q + PC_W'(1);
            end
          end else if (acc_run) begin
            state_q <= S_RUN;
            div_q   <= '0;
            skip_q  <= 1'b1;
            cnt_q   <= '0;
          end else if (cmd_acc) begin
            state_q <= S_PAUSE;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          div_q <= div_d;
          if (tc) begin
            skip_q <= 1'b0;
          end
          if (acc_halt) begin
            state_q <= S_PAUSE;
          end else if (bp_stop) begin
            state_q  <= S_PAUSE;
            bp_hit_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tis_exec_ctl.sv
// tb_tis_exec_ctl: directed scenarios followed by a randomized run, every cycle
// compared against a behavioural model of the sequencer.
module tb_tis_exec_ctl;

  localparam int PROG_DEPTH = 15;
  localparam int INSTR_W    = 16;
  localparam int PC_W       = 4;
  localparam int RUN_DIV    = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [INSTR_W-1:0] cmd_data;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_wdata;
  logic [PC_W-1:0]    plength;
  logic               core_rst;
  logic               core_en;
  logic [PC_W-1:0]    core_pc;
  logic               bp_en;
  logic [PC_W-1:0]    bp_addr;
  logic [1:0]         state;
  logic               bp_hit;
  logic               load_ovf;
  logic [15:0]        instr_count;

  tis_exec_ctl #(
    .PROG_DEPTH(PROG_DEPTH),
    .INSTR_W   (INSTR_W),
    .PC_W      (PC_W),
    .RUN_DIV   (RUN_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .plength    (plength),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .core_pc    (core_pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .state      (state),
    .bp_hit     (bp_hit),
    .load_ovf   (load_ovf),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode code, list of loaded words, status flags, cycles spent in RUN.
  int          m_mode;
  logic [15:0] m_words[$];
  bit          m_ovf, m_bphit, m_wpend, m_step, m_resume;
  int          m_count, m_t, m_pc, m_waddr;
  logic [15:0] m_wdata;

  int          cyc_no = 0;
  int          pulses[$];
  logic [19:0] wlog[$];
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_words.delete(); m_ovf = 0; m_bphit = 0; m_wpend = 0; m_step = 0;
    m_resume = 0; m_count = 0; m_t = 0; m_pc = 0; m_waddr = 0; m_wdata = '0;
  endtask

  task automatic m_push(input logic [15:0] d);
    m_wpend = 1; m_waddr = m_words.size(); m_wdata = d; m_words.push_back(d);
  endtask

  task automatic m_start_load(input logic [15:0] d);
    m_words.delete(); m_ovf = 0; m_mode = 1; m_push(d);
  endtask

  task automatic m_go_run();
    m_mode = 2; m_t = 0; m_resume = 1;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic cyc(input bit v, input logic [1:0] op, input logic [15:0] d, input bit r);
    int sz;
    bit rdy, acc, halt, term, bpstop, en;
    cmd_valid = v; cmd_op = op; cmd_data = d; rst = r; core_pc = 4'(m_pc);
    #2;
    sz     = m_words.size();
    rdy    = !r && !m_wpend;
    acc    = v && rdy;
    halt   = acc && (op == OP_HALT);
    term   = (m_mode == 2) && (((m_t + 1) % RUN_DIV) == 0);
    bpstop = term && !m_resume && (bp_en == 1'b1) && (m_pc == int'(bp_addr)) && !halt;
    en     = !r && (m_step || (term && !halt && !bpstop && sz > 0));
    chk("cmd_ready", cmd_ready, rdy);
    chk("state", state, m_mode);
    chk("core_rst", core_rst, (m_mode < 2));
    chk("core_en", core_en, en);
    chk("prog_we", prog_we, m_wpend);
    if (m_wpend) begin
      chk("prog_addr", prog_addr, m_waddr);
      chk("prog_wdata", prog_wdata, m_wdata);
    end
    chk("plength", plength, sz);
    chk("bp_hit", bp_hit, m_bphit);
    chk("load_ovf", load_ovf, m_ovf);
    chk("instr_count", instr_count, m_count);
    if (core_en === 1'b1) pulses.push_back(cyc_no);
    if (prog_we === 1'b1) wlog.push_back({prog_addr, prog_wdata});
    last_acc = acc;

    if (r) begin
      model_reset();
    end else begin
      if (en) begin
        if (m_count < 65535) m_count++;
        if (sz > 0) m_pc = (m_pc + 1) % sz;
      end
      m_wpend = 0;
      m_step  = 0;
      if (acc && op != OP_HALT) m_bphit = 0;
      case (m_mode)
        0, 3: if (acc) begin
          if (op == OP_LOAD) m_start_load(d);
          else if (op == OP_RUN) m_go_run();
          else if (op == OP_STEP) begin
            if (m_mode == 3 && sz > 0) m_step = 1;
            m_mode = 3;
          end else m_mode = 3;
        end
        1: if (acc) begin
          if (op == OP_LOAD) begin
            if (sz == PROG_DEPTH) m_ovf = 1;
            else m_push(d);
          end else begin
            m_count = 0;
            if (op == OP_RUN) m_go_run();
            else m_mode = 3;
          end
        end
        default: begin
          if (halt) m_mode = 3;
          else if (bpstop) begin
            m_mode = 3; m_bphit = 1;
          end
          if (term) m_resume = 0;
          m_t++;
        end
      endcase
      if (m_mode < 2) m_pc = 0;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, OP_LOAD, 16'h0, 1'b0);
  endtask

  // Offer a command until accepted, bounded to a few cycles.
  task automatic send(input logic [1:0] op, input logic [15:0] d);
    bit done;
    done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      cyc(1'b1, op, d, 1'b0);
      done = last_acc;
    end
    chk("send_accepted", done, 1'b1);
  endtask

  initial begin
    int c0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_LOAD; cmd_data = '0;
    core_pc = '0; bp_en = 1'b0; bp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset: outputs at reset values, nothing accepted while rst is high.
    cyc(1'b0, OP_LOAD, 16'h0, 1'b1);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prog_wdata", prog_wdata, 0);
    chk("rst_core_rst", core_rst, 1'b1);
    cyc(1'b1, OP_LOAD, 16'h1234, 1'b1);
    idle(1);

    // Load three words from IDLE.
    wlog.delete();
    send(OP_LOAD, 16'hA0A0);
    send(OP_LOAD, 16'hB1B1);
    send(OP_LOAD, 16'hC2C2);
    idle(1);
    chk("load3_writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("load3_w0", wlog[0], {4'd0, 16'hA0A0});
      chk("load3_w1", wlog[1], {4'd1, 16'hB1B1});
      chk("load3_w2", wlog[2], {4'd2, 16'hC2C2});
    end
    chk("load3_plength", plength, 3);

    // RUN: one pulse every RUN_DIV cycles.
    pulses.delete();
    send(OP_RUN, 16'h0);
    idle(12);
    chk("run_pulses", pulses.size(), 3);
    if (pulses.size() >= 3) begin
      chk("run_gap1", pulses[1] - pulses[0], RUN_DIV);
      chk("run_gap2", pulses[2] - pulses[1], RUN_DIV);
    end
    chk("run_count", instr_count, 3);
    send(OP_HALT, 16'h0);

    // Breakpoint at pc 2, then resume past it.
    bp_en = 1'b1; bp_addr = 4'd2;
    send(OP_LOAD, 16'hA0A0);
    send(OP_LOAD, 16'hB1B1);
    send(OP_LOAD, 16'hC2C2);
    send(OP_RUN, 16'h0);
    for (int i = 0; i < 40 && state !== 2'b11; i++) idle(1);
    chk("bp_state", state, 2'b11);
    chk("bp_hit_set", bp_hit, 1'b1);
    chk("bp_count", instr_count, 2);
    send(OP_RUN, 16'h0);
    idle(4);
    chk("bp_hit_clr", bp_hit, 1'b0);
    chk("bp_resume_count", instr_count, 3);
    send(OP_HALT, 16'h0);
    bp_en = 1'b0;

    // Three STEPs from PAUSE.
    pulses.delete();
    c0 = instr_count;
    repeat (3) send(OP_STEP, 16'h0);
    idle(1);
    chk("step_pulses", pulses.size(), 3);
    chk("step_count", instr_count, c0 + 3);

    // HALT on the terminal count suppresses the pulse.
    send(OP_RUN, 16'h0);
    idle(3);
    pulses.delete();
    c0 = instr_count;
    cyc(1'b1, OP_HALT, 16'h0, 1'b0);
    idle(1);
    chk("halt_tc_pulses", pulses.size(), 0);
    chk("halt_tc_state", state, 2'b11);
    chk("halt_tc_count", instr_count, c0);

    // Sixteen words: fifteen writes, last one dropped.
    wlog.delete();
    for (int i = 0; i < 16; i++) send(OP_LOAD, 16'(16'h0F00 + i * 16'h0101));
    idle(1);
    chk("ovf_writes", wlog.size(), 15);
    if (wlog.size() == 15) chk("ovf_last_addr", wlog[14][19:16], 14);
    chk("ovf_flag", load_ovf, 1'b1);
    chk("ovf_plength", plength, 15);

    // Reset mid-RUN.
    send(OP_RUN, 16'h0);
    idle(6);
    cyc(1'b0, OP_LOAD, 16'h0, 1'b1);
    chk("rstrun_state", state, 2'b00);
    chk("rstrun_core_rst", core_rst, 1'b1);
    chk("rstrun_count", instr_count, 0);
    chk("rstrun_plength", plength, 0);

    // Reset while a write is pending.
    send(OP_LOAD, 16'h5A5A);
    cyc(1'b0, OP_LOAD, 16'h0, 1'b1);
    chk("rstload_we", prog_we, 1'b0);
    chk("rstload_plength", plength, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit          rv, vv;
      logic [1:0]  opv;
      logic [15:0] dv;
      rv  = ($urandom % 150) == 0;
      vv  = ($urandom % 4) == 0;
      opv = 2'($urandom % 4);
      dv  = 16'($urandom);
      if (($urandom % 16) == 0) bp_en = 1'($urandom % 2);
      bp_addr = 4'($urandom % 4);
      cyc(vv, opv, dv, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
